// File: rtl/piradip_axis_trigger_gate_pkg.sv
// Shared types for the triggered AXI-Stream gate.
package piradip_trigger_gate_pkg;

    typedef enum logic [1:0] {
        TG_IDLE  = 2'd0,
        TG_ARMED = 2'd1,
        TG_DELAY = 2'd2,
        TG_PASS  = 2'd3
    } tg_state_t;

endpackage

// File: rtl/piradip_axis_trigger_gate_out_reg.sv
// Single-entry AXI-Stream output register. Ready passes straight through
// when the register drains in the same cycle, so a full-rate stream has no bubbles.
module piradip_axis_out_reg #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic                  in_tlast,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tlast,
    output logic                  out_tvalid,
    input  logic                  out_tready
);

    assign in_tready = ~out_tvalid | out_tready;

    // Load on an input handshake, otherwise empty once the held beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tlast  <= 1'b0;
        end else if (in_tvalid && in_tready) begin
            out_tvalid <= 1'b1;
            out_tdata  <= in_tdata;
            out_tlast  <= in_tlast;
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/piradip_axis_trigger_gate.sv
// Trigger gate: discards a looping sample stream except for a LENGTH-beat
// window that starts DELAY beats after a trigger rising edge.
module piradip_axis_trigger_gate
    import piradip_trigger_gate_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [DATA_WIDTH-1:0]  in_tdata,
    input  logic                   in_tvalid,
    output logic                   in_tready,
    output logic [DATA_WIDTH-1:0]  out_tdata,
    output logic                   out_tvalid,
    input  logic                   out_tready,
    output logic                   out_tlast,
    input  logic                   trigger,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   auto_rearm,
    input  logic [COUNT_WIDTH-1:0] delay,
    input  logic [COUNT_WIDTH-1:0] length,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] missed_triggers
);

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    tg_state_t              state;
    tg_state_t              end_state;
    logic                   trig_q;
    logic                   trig_edge;
    logic [COUNT_WIDTH-1:0] dcnt;
    logic [COUNT_WIDTH-1:0] pcnt;
    logic                   reg_ready;
    logic                   in_beat;
    logic                   pass_beat;
    logic                   zero_len;
    logic                   in_window;

    assign trig_edge = trigger & ~trig_q;
    assign end_state = auto_rearm ? TG_ARMED : TG_IDLE;
    assign in_window = (state == TG_DELAY) || (state == TG_PASS);

    // Outside PASS the upstream loop is never stalled; beats are simply dropped.
    assign in_tready = (state == TG_PASS) ? reg_ready : 1'b1;
    assign in_beat   = in_tvalid & in_tready;
    // An abort wins over the beat arriving in the same cycle: it is consumed, not forwarded.
    assign pass_beat = in_beat & (state == TG_PASS) & ~abort;
    assign zero_len  = (state == TG_ARMED) & trig_edge & (length == '0) & ~abort;

    assign busy = (state != TG_IDLE);
    assign done = ~rst_in & ((out_tvalid & out_tready & out_tlast) | zero_len);

    // Previous trigger level for rising-edge detection.
    always_ff @(posedge clk_in) begin
        if (rst_in) trig_q <= 1'b0;
        else        trig_q <= trigger;
    end

    // Window FSM with beat counters; delay/length are captured only at the edge.
    always_ff @(posedge clk_in) begin
        if (rst_in || abort) begin
            state <= TG_IDLE;
            dcnt  <= '0;
            pcnt  <= '0;
        end else begin
            case (state)
                TG_IDLE: begin
                    if (arm) state <= TG_ARMED;
                end
                TG_ARMED: begin
                    if (trig_edge) begin
                        dcnt <= delay;
                        pcnt <= length;
                        if (length == '0)     state <= end_state;
                        else if (delay == '0) state <= TG_PASS;
                        else                  state <= TG_DELAY;
                    end
                end
                TG_DELAY: begin
                    if (in_beat) begin
                        dcnt <= dcnt - ONE;
                        if (dcnt == ONE) state <= TG_PASS;
                    end
                end
                TG_PASS: begin
                    if (in_beat) begin
                        pcnt <= pcnt - ONE;
                        if (pcnt == ONE) state <= end_state;
                    end
                end
                default: state <= TG_IDLE;
            endcase
        end
    end

    // Saturating count of edges that arrive while a window is already running.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            missed_triggers <= '0;
        end else if (!abort) begin
            if (state == TG_IDLE && arm)
                missed_triggers <= '0;
            else if (trig_edge && in_window && missed_triggers != '1)
                missed_triggers <= missed_triggers + ONE;
        end
    end

    piradip_axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk        (clk_in),
        .rst        (rst_in),
        .in_tdata   (in_tdata),
        .in_tlast   (pcnt == ONE),
        .in_tvalid  (pass_beat),
        .in_tready  (reg_ready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
    );

endmodule
